alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter CHAIN_ZERO, default 1: when 1, a carry-chained operation ANDs the new zero result with the previous flag_z, giving a multi-byte zero test.
REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: request an operation; sampled only in IDLE.
- op, in, 8: ALU control code, forwarded as alu_cins.
- a_in, in, 8: operand A.
- b_in, in, 8: operand B.
- use_carry, in, 1: chain the stored carry flag into the ALU carry input.
- flag_clr, in, 1: synchronous clear of all flags.
- alu_a, out, 8: operand A to the ALU.
- alu_b, out, 8: operand B to the ALU.
- alu_cins, out, 8: ALU control code.
- alu_oe, out, 1: ALU output enable.
- alu_carryin, out, 1: carry into the ALU.
- alu_result, in, 8: ALU result.
- alu_carry, in, 1: ALU carry out.
- alu_over, in, 1: ALU overflow.
- alu_cmp, in, 1: ALU compare output.
- busy, out, 1: high in EXEC and WB.
- done, out, 1: one-cycle pulse; result is valid.
- result, out, 8: captured ALU result.
- flag_c, out, 1: carry flag.
- flag_z, out, 1: zero flag.
- flag_o, out, 1: overflow flag.
- flag_s, out, 1: sign flag.
- cmp_flag, out, 1: captured compare flag.

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, EXEC and WB; after reset it SHALL be in IDLE.
REQ-004 IDLE with start=1 SHALL latch op, a_in, b_in and use_carry into internal registers and move to EXEC on the next edge.
REQ-005 IDLE with start=0 SHALL hold state; all registered outputs SHALL keep their values.
REQ-006 alu_a, alu_b and alu_cins SHALL always drive the latched registers.
REQ-007 alu_oe SHALL be 1 only in EXEC.
REQ-008 alu_carryin SHALL equal latched use_carry AND flag_c while in EXEC, and 0 otherwise.
REQ-009 EXEC SHALL last exactly one cycle; on its closing edge the block SHALL capture:
- result <= alu_result
- flag_c <= alu_carry
- flag_o <= alu_over
- flag_s <= alu_result[7]
- cmp_flag <= alu_cmp
REQ-010 flag_z on the EXEC closing edge SHALL be (alu_result==0) AND flag_z when CHAIN_ZERO=1 and latched use_carry=1; otherwise it SHALL be (alu_result==0).
REQ-011 The FSM SHALL move EXEC->WB; in WB done=1 for exactly one cycle, then the FSM SHALL move WB->IDLE unconditionally.
REQ-012 Latency: start sampled on edge N SHALL produce done high during cycle N+2, with result and flags stable from that same edge.
REQ-013 Back-to-back: start may be accepted on the first IDLE cycle after WB, giving a minimum issue interval of 3 cycles.
REQ-014 start while busy=1 SHALL be ignored (no queueing), and the latched inputs SHALL remain unchanged.
REQ-015 busy SHALL be 1 in EXEC and WB, and 0 in IDLE.
REQ-016 flag_clr=1 SHALL clear flag_c, flag_z, flag_o, flag_s and cmp_flag on the next edge in any state.
REQ-017 When flag_clr=1 coincides with an EXEC capture edge, the capture SHALL win.
REQ-018 flag_clr SHALL NOT affect result.
REQ-019 All arithmetic decisions SHALL be taken by the external ALU; the block SHALL perform no 8-bit arithmetic beyond the zero detect.

Reset
REQ-020 While rst_n=0, asynchronously:
- state = IDLE
- latched op, a, b and use_carry = 0
- result = 0x00
- all flags = 0
- busy = 0, done = 0, alu_oe = 0, alu_carryin = 0
REQ-021 Reset asserted in EXEC or WB SHALL abort the operation: no done pulse is issued and no capture occurs.
REQ-022 The first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-023 Add overflow: start, op=0x00, a=0x7F, b=0x01, ALU stub returns 0x80, carry=0, over=1 -> done at N+2, result=0x80, flag_s=1, flag_o=1, flag_z=0, flag_c=0.
REQ-024 16-bit chain:
- Low byte: a=0xFF, b=0x01, use_carry=0; stub returns 0x00, carry=1 -> flag_c=1, flag_z=1.
- High byte: a=0x00, b=0x00, use_carry=1 -> alu_carryin=1 during EXEC.
- Stub returns 0x01 -> flag_z=0, flag_c=0.
REQ-025 Chained zero, CHAIN_ZERO=1: low byte returns 0x00 (flag_z=1), then chained op returns 0x00 -> flag_z=1; repeat with low byte 0x05 -> flag_z=0 after the chained op.
REQ-026 Busy rejection: start held high for 6 cycles with a_in changing every cycle -> exactly two operations, accepted at N and N+3, each using the a_in sampled at its accept edge.
REQ-027 flag_clr during WB -> all flags 0 next edge, result unchanged; flag_clr on the EXEC closing edge -> captured flags retained.
REQ-028 rst_n pulsed low for 1 cycle during EXEC -> no done pulse, result=0x00, busy=0, and a new start afterward completes normally.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if -- bundle of every non-clock signal of the alu_seq sequencer.
//
// Request side (from the issuing master):
//   start, op, a_in, b_in, use_carry, flag_clr  -> into the sequencer
//   busy, done, result, flag_c/z/o/s, cmp_flag  <- status back to the master
// ALU side (to the external combinational ALU):
//   alu_a, alu_b, alu_cins, alu_oe, alu_carryin -> towards the ALU
//   alu_result, alu_carry, alu_over, alu_cmp    <- back from the ALU
// Debug:
//   dbg_state <- current FSM state of the sequencer
//
// Handshake: start acts as a request valid and !busy as ready. A request is
// taken on a rising edge only when start=1 and the sequencer is idle.
// Requests made while busy are dropped, not queued. done pulses for one
// cycle when result and flags hold the new values.
//
// Modports: slave is the sequencer's view, master is the environment's view
// (issuing agent plus ALU).
interface alu_seq_if;
   logic       start;
   logic [7:0] op;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       use_carry;
   logic       flag_clr;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_cins;
   logic       alu_oe;
   logic       alu_carryin;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       alu_over;
   logic       alu_cmp;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       flag_c;
   logic       flag_z;
   logic       flag_o;
   logic       flag_s;
   logic       cmp_flag;
   logic [1:0] dbg_state;

   modport slave (
      input  start, op, a_in, b_in, use_carry, flag_clr,
      input  alu_result, alu_carry, alu_over, alu_cmp,
      output alu_a, alu_b, alu_cins, alu_oe, alu_carryin,
      output busy, done, result, flag_c, flag_z, flag_o, flag_s, cmp_flag,
      output dbg_state
   );

   modport master (
      output start, op, a_in, b_in, use_carry, flag_clr,
      output alu_result, alu_carry, alu_over, alu_cmp,
      input  alu_a, alu_b, alu_cins, alu_oe, alu_carryin,
      input  busy, done, result, flag_c, flag_z, flag_o, flag_s, cmp_flag,
      input  dbg_state
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- three-state sequencer in front of an external 8-bit ALU.
// It latches one request, presents it to the ALU for one cycle, captures
// the ALU result and flags, then pulses done.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if.slave. Request inputs, ALU drive and return signals,
//           status outputs (busy, done, result, flags) and dbg_state.
// Parameter:
//   CHAIN_ZERO : when non-zero, an operation issued with use_carry=1 ANDs
//                its zero result with the previous flag_z. This gives a
//                zero test that spans several bytes.
module alu_seq #(
   parameter int CHAIN_ZERO = 1
) (
   input logic      clk,
   input logic      rst_n,
   alu_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] op_r;
   logic [7:0] a_r;
   logic [7:0] b_r;
   logic       uc_r;

   logic       res_zero;
   logic       chain_z;

   // The zero detect is the only data-path logic that lives in this block.
   // Every other arithmetic decision is made by the external ALU.
   assign res_zero = (bus.alu_result == 8'h00);
   assign chain_z  = (CHAIN_ZERO != 0) && uc_r;

   assign bus.alu_a     = a_r;
   assign bus.alu_b     = b_r;
   assign bus.alu_cins  = op_r;
   assign bus.dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         op_r            <= 8'h00;
         a_r             <= 8'h00;
         b_r             <= 8'h00;
         uc_r            <= 1'b0;
         bus.result      <= 8'h00;
         bus.flag_c      <= 1'b0;
         bus.flag_z      <= 1'b0;
         bus.flag_o      <= 1'b0;
         bus.flag_s      <= 1'b0;
         bus.cmp_flag    <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.alu_oe      <= 1'b0;
         bus.alu_carryin <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.flag_clr) begin
                  bus.flag_c   <= 1'b0;
                  bus.flag_z   <= 1'b0;
                  bus.flag_o   <= 1'b0;
                  bus.flag_s   <= 1'b0;
                  bus.cmp_flag <= 1'b0;
               end
               if (bus.start) begin
                  op_r     <= bus.op;
                  a_r      <= bus.a_in;
                  b_r      <= bus.b_in;
                  uc_r     <= bus.use_carry;
                  state    <= EXEC;
                  bus.busy   <= 1'b1;
                  bus.alu_oe <= 1'b1;
                  // Carry-in uses the flag value that EXEC will see.
                  // A flag_clr on this same edge has already zeroed it.
                  bus.alu_carryin <= bus.use_carry & bus.flag_c & ~bus.flag_clr;
               end
            end
            EXEC: begin
               // The capture is the only flag update in this state.
               // A simultaneous flag_clr is therefore overridden.
               bus.result   <= bus.alu_result;
               bus.flag_c   <= bus.alu_carry;
               bus.flag_o   <= bus.alu_over;
               bus.flag_s   <= bus.alu_result[7];
               bus.cmp_flag <= bus.alu_cmp;
               bus.flag_z   <= chain_z ? (res_zero & bus.flag_z) : res_zero;
               state           <= WB;
               bus.alu_oe      <= 1'b0;
               bus.alu_carryin <= 1'b0;
               bus.done        <= 1'b1;
            end
            WB: begin
               if (bus.flag_clr) begin
                  bus.flag_c   <= 1'b0;
                  bus.flag_z   <= 1'b0;
                  bus.flag_o   <= 1'b0;
                  bus.flag_s   <= 1'b0;
                  bus.cmp_flag <= 1'b0;
               end
               state    <= IDLE;
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
            end
            default: begin
               state           <= IDLE;
               bus.done        <= 1'b0;
               bus.busy        <= 1'b0;
               bus.alu_oe      <= 1'b0;
               bus.alu_carryin <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq (CHAIN_ZERO=1). A small
// behavioural ALU answers the sequencer. A per-operation model of the
// flags and result predicts every observed value.
module tb_alu_seq;

   localparam int CHAIN_ZERO = 1;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_err;

   // Model of the architectural state that is visible to software.
   logic [7:0] m_res;
   logic       m_c, m_z, m_o, m_s, m_cmp;

   alu_seq_if bus ();

   alu_seq #(.CHAIN_ZERO(CHAIN_ZERO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Test ALU: op 0 add, 1 subtract-with-carry, 2 and, 3 or, 4 xor, else pass a.
   // Returned value is {cmp, over, carry, result[7:0]}.
   function automatic logic [10:0] alu_func(input logic [7:0] o, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
      logic [8:0] s;
      logic       ov;
      ov = 1'b0;
      case (o)
         8'd0: begin
            s  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            ov = (a[7] == b[7]) && (s[7] != a[7]);
         end
         8'd1: begin
            s  = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
            ov = (a[7] != b[7]) && (s[7] != a[7]);
         end
         8'd2:    s = {1'b0, a & b};
         8'd3:    s = {1'b0, a | b};
         8'd4:    s = {1'b0, a ^ b};
         default: s = {1'b0, a};
      endcase
      return {(a == b), ov, s[8], s[7:0]};
   endfunction

   assign {bus.alu_cmp, bus.alu_over, bus.alu_carry, bus.alu_result} =
      alu_func(bus.alu_cins, bus.alu_a, bus.alu_b, bus.alu_carryin);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_arch(input string tag);
      check({tag, "_res"}, {24'd0, bus.result}, {24'd0, m_res});
      check({tag, "_flags"}, {27'd0, bus.flag_c, bus.flag_z, bus.flag_o, bus.flag_s, bus.cmp_flag},
            {27'd0, m_c, m_z, m_o, m_s, m_cmp});
   endtask

   task automatic model_capture(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b,
                                input logic uc, input logic cin);
      logic [10:0] r;
      r     = alu_func(o, a, b, cin);
      m_z   = (r[7:0] == 8'h00) && (!((CHAIN_ZERO != 0) && uc) || m_z);
      m_res = r[7:0];
      m_c   = r[8];
      m_o   = r[9];
      m_s   = r[7];
      m_cmp = r[10];
   endtask

   task automatic model_clear();
      m_c = 1'b0; m_z = 1'b0; m_o = 1'b0; m_s = 1'b0; m_cmp = 1'b0;
   endtask

   // One complete operation. It is entered at a falling edge while the DUT is idle.
   // While the DUT is busy, start stays high with junk operands, which must be ignored.
   task automatic run_op(input logic [7:0] op_v, input logic [7:0] a_v, input logic [7:0] b_v,
                         input logic uc_v, input logic clr_exec, input logic clr_wb);
      logic cin;
      cin = uc_v & m_c;
      bus.start = 1'b1; bus.op = op_v; bus.a_in = a_v; bus.b_in = b_v;
      bus.use_carry = uc_v; bus.flag_clr = 1'b0;
      @(negedge clk);
      bus.op = 8'($urandom); bus.a_in = 8'($urandom); bus.b_in = 8'($urandom);
      bus.use_carry = 1'($urandom); bus.flag_clr = clr_exec;
      check("exec_ctl", {28'd0, bus.busy, bus.done, bus.alu_oe, bus.alu_carryin},
            {28'd0, 1'b1, 1'b0, 1'b1, cin});
      check("exec_ops", {8'd0, bus.alu_cins, bus.alu_a, bus.alu_b}, {8'd0, op_v, a_v, b_v});
      model_capture(op_v, a_v, b_v, uc_v, cin);
      @(negedge clk);
      bus.flag_clr = clr_wb;
      check("wb_ctl", {28'd0, bus.busy, bus.done, bus.alu_oe, bus.alu_carryin}, 32'b1100);
      check_arch("wb");
      if (clr_wb) model_clear();
      @(negedge clk);
      bus.start = 1'b0; bus.flag_clr = 1'b0;
      check("idle_ctl", {28'd0, bus.busy, bus.done, bus.alu_oe, bus.alu_carryin}, 32'd0);
      check("idle_ops", {8'd0, bus.alu_cins, bus.alu_a, bus.alu_b}, {8'd0, op_v, a_v, b_v});
      check_arch("idle");
   endtask

   logic [7:0] av[6];
   logic       exp_busy, exp_done, clr_i;

   initial begin
      n_checks = 0; n_err = 0;
      m_res = 8'h00; model_clear();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 8'h00; bus.a_in = 8'h00; bus.b_in = 8'h00;
      bus.use_carry = 1'b0; bus.flag_clr = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_ctl", {28'd0, bus.busy, bus.done, bus.alu_oe, bus.alu_carryin}, 32'd0);
      check("rst_ops", {8'd0, bus.alu_cins, bus.alu_a, bus.alu_b}, 32'd0);
      check_arch("rst");

      // First start on the first edge after release, and add overflow.
      rst_n = 1'b1;
      run_op(8'h00, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
      check("ovf_res", {24'd0, bus.result}, 32'h80);
      check("ovf_scoz", {28'd0, bus.flag_s, bus.flag_c, bus.flag_o, bus.flag_z}, 32'b1010);

      // 16-bit add chain: the low byte carries into the high byte.
      run_op(8'h00, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      check("chain_lo_cz", {30'd0, bus.flag_c, bus.flag_z}, 32'b11);
      run_op(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      check("chain_hi_res", {24'd0, bus.result}, 32'h01);
      check("chain_hi_cz", {30'd0, bus.flag_c, bus.flag_z}, 32'b00);

      // Chained zero: both bytes zero, then a non-zero low byte.
      run_op(8'h00, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      run_op(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
      check("zchain_both", {31'd0, bus.flag_z}, 32'd1);
      run_op(8'h00, 8'h04, 8'h01, 1'b0, 1'b0, 1'b0);
      run_op(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      check("zchain_lo5", {31'd0, bus.flag_z}, 32'd0);

      // flag_clr in WB clears the flags. In EXEC, the capture wins.
      run_op(8'h00, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
      check("clr_wb_flags", {27'd0, bus.flag_c, bus.flag_z, bus.flag_o, bus.flag_s, bus.cmp_flag}, 32'd0);
      check("clr_wb_res", {24'd0, bus.result}, 32'h30);
      run_op(8'h00, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
      check("clr_exec_czo", {29'd0, bus.flag_c, bus.flag_z, bus.flag_o}, 32'b111);

      // Busy rejection: start held for 6 cycles while a_in changes every cycle.
      bus.op = 8'h00; bus.b_in = 8'h03; bus.use_carry = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.start = 1'b1;
         bus.a_in  = 8'($urandom);
         av[i]     = bus.a_in;
         @(negedge clk);
         exp_busy = (i != 2) && (i != 5);
         exp_done = (i == 1) || (i == 4);
         check("rej_ctl", {30'd0, bus.busy, bus.done}, {30'd0, exp_busy, exp_done});
         if (exp_done) begin
            model_capture(8'h00, av[i-1], 8'h03, 1'b0, 1'b0);
            check("rej_a", {24'd0, bus.alu_a}, {24'd0, av[i-1]});
            check_arch("rej");
         end
      end
      bus.start = 1'b0;

      // A reset pulse during EXEC aborts the operation.
      bus.start = 1'b1; bus.op = 8'h00; bus.a_in = 8'h11; bus.b_in = 8'h22;
      @(negedge clk);
      bus.start = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort_ctl", {28'd0, bus.busy, bus.done, bus.alu_oe, bus.alu_carryin}, 32'd0);
      m_res = 8'h00; model_clear();
      check_arch("abort");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_after", {30'd0, bus.busy, bus.done}, 32'd0);
      check_arch("abort_after");
      run_op(8'h01, 8'h50, 8'h20, 1'b0, 1'b0, 1'b0);

      // Random operations, with idle gaps that hold state or clear the flags.
      for (int k = 0; k < 24; k++) begin
         run_op(8'($urandom_range(5, 0)), 8'($urandom), 8'($urandom), 1'($urandom),
                ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0));
         for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
            clr_i = ($urandom_range(3, 0) == 0);
            bus.flag_clr = clr_i;
            @(negedge clk);
            bus.flag_clr = 1'b0;
            if (clr_i) model_clear();
            check("gap_ctl", {30'd0, bus.busy, bus.done}, 32'd0);
            check_arch("gap");
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
